// File: rtl/id_stage_pipe.sv
// Decode stage: opcode decode, 8-entry register file, load-use stall and ID/EX register.
// Optional same-cycle writeback-to-read bypass under macro ID_WB_BYPASS_EN.
module id_stage_pipe #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [15:0]       instruction,
  input  logic              flush,
  input  logic              wb_reg_write,
  input  logic [2:0]        wb_register,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_read_data_1,
  output logic [DATA_W-1:0] ex_read_data_2,
  output logic [DATA_W-1:0] ex_immediate,
  output logic [2:0]        ex_rs,
  output logic [2:0]        ex_rt,
  output logic [2:0]        ex_dest,
  output logic              ex_ALUSrc,
  output logic              ex_MemtoReg,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_Branch,
  output logic              ex_RegWrite,
  output logic [1:0]        ex_ALUOp
);

  logic [2:0] op, rs, rt, rd;
  logic [6:0] imm;
  assign op  = instruction[15:13];
  assign rs  = instruction[12:10];
  assign rt  = instruction[9:7];
  assign rd  = instruction[6:4];
  assign imm = instruction[6:0];

  logic       reg_dst, alu_src, mem_to_reg, mem_read, mem_write, branch, reg_write;
  logic [1:0] alu_op;
  logic       uses_rs, uses_rt;

  always_comb begin
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    uses_rs    = 1'b0;
    uses_rt    = 1'b0;
    unique case (op)
      3'b000: begin
        reg_dst = 1'b1; reg_write = 1'b1; alu_op = 2'b10; uses_rs = 1'b1; uses_rt = 1'b1;
      end
      3'b001: begin
        alu_src = 1'b1; reg_write = 1'b1; uses_rs = 1'b1;
      end
      3'b010: begin
        alu_src = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1; uses_rs = 1'b1;
      end
      3'b011: begin
        alu_src = 1'b1; mem_write = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1;
      end
      3'b100: begin
        branch = 1'b1; alu_op = 2'b01; uses_rs = 1'b1; uses_rt = 1'b1;
      end
      default: ;
    endcase
  end

  // Register file; with ZERO_REG, writes to R0 are dropped and R0 reads as zero.
  logic [DATA_W-1:0] regs_q [8];
  logic              wb_en;
  assign wb_en = wb_reg_write && !((ZERO_REG != 0) && (wb_register == 3'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (wb_en) begin
      regs_q[wb_register] <= wb_data;
    end
  end

  logic [DATA_W-1:0] rdata_1, rdata_2;
  always_comb begin
    rdata_1 = regs_q[rs];
    rdata_2 = regs_q[rt];
`ifdef ID_WB_BYPASS_EN
    if (wb_en && (wb_register == rs)) rdata_1 = wb_data;
    if (wb_en && (wb_register == rt)) rdata_2 = wb_data;
`endif
    if ((ZERO_REG != 0) && (rs == 3'd0)) rdata_1 = '0;
    if ((ZERO_REG != 0) && (rt == 3'd0)) rdata_2 = '0;
  end

  logic [2:0] dest;
  logic       dest_hit;
  assign dest     = reg_dst ? rd : rt;
  assign dest_hit = (uses_rs && (rs == ex_dest)) || (uses_rt && (rt == ex_dest));
  assign stall    = in_valid && ex_valid && ex_MemRead && dest_hit &&
                    !((ZERO_REG != 0) && (ex_dest == 3'd0));

  always_ff @(posedge clk) begin
    if (rst || flush || stall || !in_valid) begin
      ex_valid       <= 1'b0;
      ex_read_data_1 <= '0;
      ex_read_data_2 <= '0;
      ex_immediate   <= '0;
      ex_rs          <= '0;
      ex_rt          <= '0;
      ex_dest        <= '0;
      ex_ALUSrc      <= 1'b0;
      ex_MemtoReg    <= 1'b0;
      ex_MemRead     <= 1'b0;
      ex_MemWrite    <= 1'b0;
      ex_Branch      <= 1'b0;
      ex_RegWrite    <= 1'b0;
      ex_ALUOp       <= 2'b00;
    end else begin
      ex_valid       <= 1'b1;
      ex_read_data_1 <= rdata_1;
      ex_read_data_2 <= rdata_2;
      ex_immediate   <= {{(DATA_W-7){imm[6]}}, imm};
      ex_rs          <= rs;
      ex_rt          <= rt;
      ex_dest        <= dest;
      ex_ALUSrc      <= alu_src;
      ex_MemtoReg    <= mem_to_reg;
      ex_MemRead     <= mem_read;
      ex_MemWrite    <= mem_write;
      ex_Branch      <= branch;
      ex_RegWrite    <= reg_write;
      ex_ALUOp       <= alu_op;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed self-checking bench for id_stage_pipe (DATA_W=16, ZERO_REG=1).
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, wb_reg_write;
  logic [15:0] instruction;
  logic [2:0]  wb_register;
  logic [15:0] wb_data;
  logic        stall, ex_valid;
  logic [15:0] ex_read_data_1, ex_read_data_2, ex_immediate;
  logic [2:0]  ex_rs, ex_rt, ex_dest;
  logic        ex_ALUSrc, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_Branch, ex_RegWrite;
  logic [1:0]  ex_ALUOp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.DATA_W(16), .ZERO_REG(1)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .instruction    (instruction),
    .flush          (flush),
    .wb_reg_write   (wb_reg_write),
    .wb_register    (wb_register),
    .wb_data        (wb_data),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .ex_read_data_1 (ex_read_data_1),
    .ex_read_data_2 (ex_read_data_2),
    .ex_immediate   (ex_immediate),
    .ex_rs          (ex_rs),
    .ex_rt          (ex_rt),
    .ex_dest        (ex_dest),
    .ex_ALUSrc      (ex_ALUSrc),
    .ex_MemtoReg    (ex_MemtoReg),
    .ex_MemRead     (ex_MemRead),
    .ex_MemWrite    (ex_MemWrite),
    .ex_Branch      (ex_Branch),
    .ex_RegWrite    (ex_RegWrite),
    .ex_ALUOp       (ex_ALUOp)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rs,
                                     input logic [2:0] rt, input logic [6:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input logic [2:0] r, input logic [15:0] d);
    in_valid     = 1'b0;
    wb_reg_write = 1'b1;
    wb_register  = r;
    wb_data      = d;
    step();
    wb_reg_write = 1'b0;
  endtask

  // Concatenated control word {ALUSrc,MemtoReg,MemRead,MemWrite,Branch,RegWrite,ALUOp}
  function automatic logic [7:0] ctl();
    return {ex_ALUSrc, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_Branch, ex_RegWrite, ex_ALUOp};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_reg_write = 1'b0;
    instruction = '0; wb_register = '0; wb_data = '0;
    step(); step();
    check("rst_valid", ex_valid, 0);
    check("rst_ctl", ctl(), 0);
    check("rst_stall", stall, 0);

    // R-type rs=1 rt=2 rd=3 right after reset
    rst = 1'b0; in_valid = 1'b1;
    instruction = mk(3'b000, 3'd1, 3'd2, 7'h30);
    step();
    check("rt_valid", ex_valid, 1);
    check("rt_rd1", ex_read_data_1, 16'h0);
    check("rt_rd2", ex_read_data_2, 16'h0);
    check("rt_ctl", ctl(), 8'b0000_0110);
    check("rt_dest", ex_dest, 3);

    // Writes, including one to R0 that must be dropped
    wb_write(3'd3, 16'h1234);
    check("idle_bubble", ex_valid, 0);
    wb_write(3'd6, 16'h0001);
    wb_write(3'd0, 16'hAAAA);

    in_valid = 1'b1;
    instruction = mk(3'b001, 3'd3, 3'd1, 7'h7F);
    step();
    check("addi_rd1", ex_read_data_1, 16'h1234);
    check("addi_imm", ex_immediate, 16'hFFFF);
    check("addi_ctl", ctl(), 8'b1000_0100);
    check("addi_dest", ex_dest, 1);

    instruction = mk(3'b000, 3'd0, 3'd3, 7'h10);
    step();
    check("r0_reads_zero", ex_read_data_1, 16'h0);
    check("r3_rt", ex_read_data_2, 16'h1234);

    // Load-use on rs: one stall, one bubble
    instruction = mk(3'b010, 3'd1, 3'd4, 7'h02);
    step();
    check("lw_ctl", ctl(), 8'b1110_0100);
    check("lw_dest", ex_dest, 4);
    check("lw_imm", ex_immediate, 16'h0002);
    instruction = mk(3'b000, 3'd4, 3'd2, 7'h50);
    #1 check("lu_stall", stall, 1);
    step();
    check("lu_bubble", ex_valid, 0);
    check("lu_bubble_ctl", ctl(), 0);
    check("lu_stall_drop", stall, 0);
    step();
    check("lu_emerge_valid", ex_valid, 1);
    check("lu_emerge_rs", ex_rs, 4);
    check("lu_emerge_dest", ex_dest, 5);

    // SW uses rt -> stall; ADDI ignores rt -> no stall
    instruction = mk(3'b010, 3'd1, 3'd5, 7'h00);
    step();
    instruction = mk(3'b011, 3'd1, 3'd5, 7'h01);
    #1 check("sw_stall", stall, 1);
    step();
    check("sw_stall_drop", stall, 0);
    step();
    check("sw_ctl", ctl(), 8'b1001_0000);
    check("sw_rt", ex_rt, 5);
    instruction = mk(3'b010, 3'd1, 3'd5, 7'h00);
    step();
    instruction = mk(3'b001, 3'd1, 3'd5, 7'h01);
    #1 check("addi_no_stall", stall, 0);
    step();
    check("addi_after_lw", ex_valid, 1);

    // Flush during stall
    instruction = mk(3'b010, 3'd1, 3'd4, 7'h00);
    step();
    instruction = mk(3'b000, 3'd4, 3'd2, 7'h50);
    flush = 1'b1;
    #1 check("flush_stall", stall, 1);
    step();
    flush = 1'b0;
    check("flush_valid", ex_valid, 0);
    check("flush_ctl", ctl(), 0);

    // LW to R0 never stalls
    instruction = mk(3'b010, 3'd1, 3'd0, 7'h00);
    step();
    instruction = mk(3'b000, 3'd0, 3'd2, 7'h50);
    #1 check("r0_no_stall", stall, 0);

    // BEQ and NOP decode
    instruction = mk(3'b100, 3'd1, 3'd2, 7'h05);
    step();
    check("beq_ctl", ctl(), 8'b0000_1001);
    instruction = mk(3'b111, 3'd3, 3'd3, 7'h05);
    step();
    check("nop_valid", ex_valid, 1);
    check("nop_ctl", ctl(), 0);

    // Same-cycle writeback to a register being read
    instruction = mk(3'b000, 3'd6, 3'd2, 7'h00);
    wb_reg_write = 1'b1; wb_register = 3'd6; wb_data = 16'hBEEF;
    step();
    wb_reg_write = 1'b0;
`ifdef ID_WB_BYPASS_EN
    check("wb_same_cycle", ex_read_data_1, 16'hBEEF);
`else
    check("wb_same_cycle", ex_read_data_1, 16'h0001);
`endif
    step();
    check("wb_next_cycle", ex_read_data_1, 16'hBEEF);

    // Reset mid-stall clears ID/EX and the register file
    instruction = mk(3'b010, 3'd1, 3'd4, 7'h00);
    step();
    instruction = mk(3'b000, 3'd4, 3'd3, 7'h00);
    #1 check("pre_rst_stall", stall, 1);
    rst = 1'b1;
    step();
    check("rst_mid_valid", ex_valid, 0);
    check("rst_mid_stall", stall, 0);
    rst = 1'b0;
    instruction = mk(3'b000, 3'd3, 3'd6, 7'h00);
    step();
    check("rst_clr_r3", ex_read_data_1, 16'h0);
    check("rst_clr_r6", ex_read_data_2, 16'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
